// File: rtl/comb_diff_mc.sv
// rtl/comb_diff_mc.sv - multi-channel registered comb stage y[n] = x[n] - x[n-DEPTH]
//
// Purpose:
//   Time-interleaved comb (difference) stage for the decimation datapath.
//   Each channel owns a DEPTH-deep circular delay line, and all channels share
//   one write pointer. Every accepted sample reads the oldest stored value of
//   its channel and overwrites it in the same cycle. The difference is
//   registered, so latency is one clock.
//
// Optional feature:
//   COMB_DIFF_SAT_EN - clamp the result to [-2^NBITS, 2^NBITS-1] and flag the
//                      clamp on out_sat. When undefined, the result wraps and
//                      out_sat is tied to 0.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   clear       in   synchronous flush of delay line, channel counter, pointer
//   SIG_IN      in   NBITS+1 two's complement sample for the current channel
//   in_valid    in   SIG_IN valid (no backpressure)
//   sig_out_sub out  registered difference
//   out_valid   out  sig_out_sub valid
//   out_ch      out  channel index of sig_out_sub
//   out_sat     out  result was clamped
module comb_diff_mc #(
  parameter int NBITS = 2,
  parameter int DEPTH = 1,
  parameter int CH    = 1,
  localparam int W    = NBITS + 1,
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic [W-1:0]   SIG_IN,
  input  logic           in_valid,
  output logic [W-1:0]   sig_out_sub,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic           out_sat
);

  localparam int WPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]   r_mem [CH][DEPTH];
  logic [CHW-1:0] r_ch;
  logic [WPW-1:0] r_wp;
  logic [W-1:0]   r_sig_out;
  logic           r_out_valid;
  logic [CHW-1:0] r_out_ch;

  logic [W-1:0]   w_old;
  logic [W-1:0]   w_res;
  logic           w_ch_last;
  logic           w_wp_last;

  // Slot select by comparison against loop constants keeps the index widths
  // exact for every CH/DEPTH, including the single-entry cases.
  always_comb begin
    w_old = '0;
    for (int c = 0; c < CH; c++) begin
      for (int d = 0; d < DEPTH; d++) begin
        if (r_ch == CHW'(c) && r_wp == WPW'(d)) begin
          w_old = r_mem[c][d];
        end
      end
    end
  end

  assign w_ch_last = (r_ch == CHW'(CH - 1));
  assign w_wp_last = (r_wp == WPW'(DEPTH - 1));

`ifdef COMB_DIFF_SAT_EN
  logic [W:0] w_diff;
  logic       w_ovf;
  logic       r_out_sat;

  // One guard bit: overflow shows up as the top two bits disagreeing, and the
  // guard bit then carries the true sign, which picks the clamp rail.
  assign w_diff = {SIG_IN[W-1], SIG_IN} - {w_old[W-1], w_old};
  assign w_ovf  = w_diff[W] ^ w_diff[W-1];
  assign w_res  = w_ovf ? {w_diff[W], {(W-1){~w_diff[W]}}} : w_diff[W-1:0];
  assign out_sat = r_out_sat;
`else
  // Without clamping only the low W bits matter, and they are identical to
  // the wide difference truncated, so a W-bit subtractor is enough.
  assign w_res   = SIG_IN - w_old;
  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        for (int d = 0; d < DEPTH; d++) begin
          r_mem[c][d] <= '0;
        end
      end
      r_ch        <= '0;
      r_wp        <= '0;
      r_sig_out   <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
`ifdef COMB_DIFF_SAT_EN
      r_out_sat   <= 1'b0;
`endif
    end else if (clear) begin
      // Clear wins over a coincident sample; output data fields hold.
      for (int c = 0; c < CH; c++) begin
        for (int d = 0; d < DEPTH; d++) begin
          r_mem[c][d] <= '0;
        end
      end
      r_ch        <= '0;
      r_wp        <= '0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      for (int c = 0; c < CH; c++) begin
        for (int d = 0; d < DEPTH; d++) begin
          if (r_ch == CHW'(c) && r_wp == WPW'(d)) begin
            r_mem[c][d] <= SIG_IN;
          end
        end
      end
      r_ch <= w_ch_last ? '0 : r_ch + CHW'(1);
      // The shared pointer advances once per full round of channels.
      if (w_ch_last) begin
        r_wp <= w_wp_last ? '0 : r_wp + WPW'(1);
      end
      r_sig_out   <= w_res;
      r_out_valid <= 1'b1;
      r_out_ch    <= r_ch;
`ifdef COMB_DIFF_SAT_EN
      r_out_sat   <= w_ovf;
`endif
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign sig_out_sub = r_sig_out;
  assign out_valid   = r_out_valid;
  assign out_ch      = r_out_ch;

endmodule

// File: tb/tb_comb_diff_mc.sv
// tb/tb_comb_diff_mc.sv - self-checking bench for comb_diff_mc (NBITS=2, DEPTH=2, CH=2)
module tb_comb_diff_mc;

  localparam int NB = 2;
  localparam int DP = 2;
  localparam int NC = 2;
`ifdef COMB_DIFF_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] sig_in = '0;
  logic [2:0] sig_out_sub;
  logic       out_valid;
  logic [0:0] out_ch;
  logic       out_sat;

  comb_diff_mc #(.NBITS(NB), .DEPTH(DP), .CH(NC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .SIG_IN     (sig_in),
    .in_valid   (in_valid),
    .sig_out_sub(sig_out_sub),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;

  // first: flush with clear before this entry; ew/es: expected wrap/sat result
  typedef struct {
    bit first;
    int x;
    int ch;
    int ew;
    int es;
    bit sf;
  } vec_t;

  typedef struct {
    logic [2:0] d;
    logic       ch;
    logic       sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  vec_t tv[15];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Drives one sample at the current time and records its expected output.
  task automatic drive(input int x, input int ch, input int ew, input int es, input bit sf);
    exp_t e;
    in_valid = 1'b1;
    sig_in   = 3'(x);
    e.d   = SAT ? 3'(es) : 3'(ew);
    e.ch  = 1'(ch);
    e.sat = SAT ? sf : 1'b0;
    sb.push_back(e);
  endtask

  task automatic drive_vec(input vec_t v);
    drive(v.x, v.ch, v.ew, v.es, v.sf);
  endtask

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0d ch %0d, expected no output", sig_out_sub, out_ch);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sig_out_sub", int'(sig_out_sub), int'(e.d));
        chk("out_ch", int'(out_ch), int'(e.ch));
        chk("out_sat", int'(out_sat), int'(e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // multi-channel stream A0,B0,A1,B1,A2,B2
    tv[0]  = '{1'b1,  1, 0,  1,  1, 1'b0};
    tv[1]  = '{1'b0,  2, 1,  2,  2, 1'b0};
    tv[2]  = '{1'b0,  3, 0,  3,  3, 1'b0};
    tv[3]  = '{1'b0,  1, 1,  1,  1, 1'b0};
    tv[4]  = '{1'b0, -2, 0, -3, -3, 1'b0};
    tv[5]  = '{1'b0,  0, 1, -2, -2, 1'b0};
    // overflow: A sees 3 then -4 (-7) and later -4 then 3 (+7)
    tv[6]  = '{1'b1,  3, 0,  3,  3, 1'b0};
    tv[7]  = '{1'b0,  0, 1,  0,  0, 1'b0};
    tv[8]  = '{1'b0,  0, 0,  0,  0, 1'b0};
    tv[9]  = '{1'b0,  0, 1,  0,  0, 1'b0};
    tv[10] = '{1'b0, -4, 0,  1, -4, 1'b1};
    tv[11] = '{1'b0,  0, 1,  0,  0, 1'b0};
    tv[12] = '{1'b0,  3, 0,  3,  3, 1'b0};
    tv[13] = '{1'b0,  0, 1,  0,  0, 1'b0};
    tv[14] = '{1'b0,  3, 0, -1,  3, 1'b1};

    // outputs while held in reset
    repeat (2) @(negedge clk);
    chk("rst_sig_out_sub", int'(sig_out_sub), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // priming: first sample passes through
    @(negedge clk);
    drive(3, 0, 3, 3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("prime_valid", int'(out_valid), 1);
    drain();

    // table-driven streams
    for (int i = 0; i < 15; i++) begin
      if (tv[i].first) begin
        drain();
        do_clear();
      end
      @(negedge clk);
      drive_vec(tv[i]);
    end
    drain();

    // gapped replay of the multi-channel stream
    do_clear();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) chk("gap_idle_valid", int'(out_valid), 0);
      drive_vec(tv[i]);
      for (int g = 0; g < 3; g++) begin
        @(negedge clk);
        if (g > 0) chk("gap_idle_valid", int'(out_valid), 0);
        in_valid = 1'b0;
      end
    end
    drain();

    // clear has priority over a coincident sample
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    sig_in   = 3'd2;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_drop_valid", int'(out_valid), 0);
    @(negedge clk);
    drive(2, 0, 2, 2, 1'b0);
    @(negedge clk);
    drive(1, 1, 1, 1, 1'b0);
    drain();

    // asynchronous reset between edges discards history
    @(negedge clk);
    drive(3, 0, 3, 3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_sig_out_sub", int'(sig_out_sub), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_ch", int'(out_ch), 0);
    chk("arst_out_sat", int'(out_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(-2, 0, -2, -2, 1'b0);
    @(negedge clk);
    drive(1, 1, 1, 1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
